wb_uart_tx_fifo: RTL and testbench

//  Wishbone-classic slave UART transmitter with an internal byte FIFO. Sits on the SoC Wishbone
//  bus next to the GPIO and SDRAM slaves and drives the board-level serial line (e.g. GPIO_1[1]).
//  CPU writes bytes; the block serialises them as 8N1 frames at a fixed baud rate.

---
 rtl/wb_uart_tx_fifo_pkg.sv | 39 +++
 rtl/wb_uart_tx_sync_fifo.sv | 71 +++++++
 rtl/wb_uart_tx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_wb_uart_tx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_tx_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module  : wb_uart_tx_fifo_pkg
// Brief   : Shared register map, STATUS bit positions, serialiser state
//           encoding and baud divisor helper for the Wishbone UART TX block.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_uart_tx_fifo_pkg;

    // Register selects (wb_adr_i[3:2])
    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_ctrl   = 2'd2;
    localparam logic [1:0] c_reg_rsvd   = 2'd3;

    // STATUS register bit positions
    localparam int c_st_busy  = 0;
    localparam int c_st_full  = 1;
    localparam int c_st_empty = 2;
    localparam int c_st_ovf   = 3;
    localparam int c_st_level = 8;

    // Serialiser states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per bit, rounded to nearest
    function automatic int calc_divisor(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_uart_tx_sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : wb_uart_tx_sync_fifo
// Brief   : Single-clock FIFO with occupancy level. Pushes while full and
//           pops while empty are ignored; pointers wrap modulo the depth.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_uart_tx_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                  c_depth      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_level = (DEPTH_LOG2 + 1)'(c_depth);

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_level == c_full_level);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage array: written on accepted pushes only
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and level; simultaneous push and pop leave level unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module  : wb_uart_tx_fifo
// Brief   : Wishbone-classic slave UART transmitter (8N1) with byte FIFO,
//           overflow flag and TX-empty interrupt.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_uart_tx_fifo
    import wb_uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 24000000,
    parameter int BAUD            = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        uart_tx,
    output logic        irq_o
);

    localparam int c_divisor = calc_divisor(CLK_FREQ_HZ, BAUD);
    localparam int c_baud_w  = (c_divisor < 2) ? 1 : $clog2(c_divisor);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_divisor - 1);

    generate
        if (c_divisor < 2) begin : g_bad_divisor
            $error("wb_uart_tx_fifo: baud divisor must be at least 2");
        end
    endgenerate

    logic                     r_ack;
    logic [31:0]              r_dat;
    logic                     r_ie;
    logic                     r_ovf;
    logic                     r_irq;
    logic                     r_tx;
    tx_state_t                r_state;
    logic [c_baud_w-1:0]      r_baud;
    logic [2:0]               r_bit;
    logic [7:0]               r_shift;

    logic                     w_access;
    logic                     w_wr;
    logic [1:0]               w_reg;
    logic                     w_push_req;
    logic                     w_pop;
    logic [7:0]               w_pop_data;
    logic                     w_full;
    logic                     w_empty;
    logic [FIFO_DEPTH_LOG2:0] w_level;
    logic [31:0]              w_rdata;
    logic                     w_unused;

    assign w_access   = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr       = w_access & wb_we_i;
    assign w_reg      = wb_adr_i[3:2];
    assign w_push_req = w_wr & (w_reg == c_reg_data) & wb_sel_i[0];
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_unused   = &{1'b0, wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign uart_tx  = r_tx;
    assign irq_o    = r_irq;

    wb_uart_tx_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push_req),
        .push_data (wb_dat_i[7:0]),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty),
        .level     (w_level)
    );

    // Register read multiplexer
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            c_reg_status: begin
                w_rdata[c_st_busy]  = (r_state != S_IDLE);
                w_rdata[c_st_full]  = w_full;
                w_rdata[c_st_empty] = w_empty;
                w_rdata[c_st_ovf]   = r_ovf;
                w_rdata[c_st_level +: FIFO_DEPTH_LOG2 + 1] = w_level;
            end
            c_reg_ctrl: w_rdata[0] = r_ie;
            default:    w_rdata = '0;
        endcase
    end

    // Bus handshake: one-cycle registered ack, read data captured with it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_access;
            r_dat <= (w_access & ~wb_we_i) ? w_rdata : 32'h0;
        end
    end

    // Control/status registers and interrupt; full is judged pre-edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ie  <= 1'b0;
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && w_reg == c_reg_ctrl && wb_sel_i[0]) begin
                r_ie <= wb_dat_i[0];
            end
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && w_reg == c_reg_status && wb_sel_i[0] && wb_dat_i[c_st_ovf]) begin
                r_ovf <= 1'b0;
            end
            r_irq <= r_ie & w_empty & (r_state == S_IDLE);
        end
    end

    // Serialiser: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_pop_data;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == c_baud_last) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                S_DATA: begin
                    if (r_baud == c_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                S_STOP: begin
                    if (r_baud == c_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_wb_uart_tx_fifo
// Brief   : Directed self-checking bench for wb_uart_tx_fifo
//           (DIVISOR = 10, FIFO depth 4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_uart_tx_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic        uart_tx;
    logic        irq_o;

    int errors   = 0;
    int checks   = 0;
    int cycle    = 0;
    int last_ack = 0;

    localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_CTRL = 4'h8, A_RSVD = 4'hC;

    wb_uart_tx_fifo #(
        .CLK_FREQ_HZ     (1000000),
        .BAUD            (100000),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .uart_tx  (uart_tx),
        .irq_o    (irq_o)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Advance to 1 ns after the posedge numbered t
    task automatic wait_until(input int t);
        while (cycle < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat);
        bit got;
        got = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clock);
            #1;
            if (wb_ack_o === 1'b1) got = 1'b1;
        end
        rdat = wb_dat_o;
        last_ack = cycle;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bus_ack adr=%h: no ack seen, required within 8 cycles", adr);
        end
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] unused_rd;
        bus(1'b1, adr, dat, sel, unused_rd);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] rd);
        bus(1'b0, adr, 32'h0, 4'hF, rd);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b need 1", uart_tx); end
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b need 0", wb_ack_o); end
        checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h need 0", wb_dat_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b need 0", irq_o); end
        reset = 1'b0;
        @(posedge clock);
        #1;
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL rst_status: got %h need 00000004", rd); end
        wb_read(A_CTRL, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h need 0", rd); end
    endtask

    task automatic test_single_frame;
        logic [31:0] rd;
        logic [9:0]  fr;
        int f;
        fr = {1'b1, 8'h55, 1'b0};
        wb_write(A_DATA, 32'h55, 4'h1);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL sf_pre_fall: got %b need 1", uart_tx); end
        f = last_ack + 1;
        wait_until(f);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL sf_fall: got %b need 0", uart_tx); end
        for (int k = 0; k < 10; k++) begin
            wait_until(f + 10 * k + 5);
            checks++;
            if (uart_tx !== fr[k]) begin errors++; $display("FAIL sf_bit%0d: got %b need %b", k, uart_tx, fr[k]); end
            if (k == 4) begin
                wb_read(A_STAT, rd);
                checks++; if (rd !== 32'h5) begin errors++; $display("FAIL sf_busy: got %h need 00000005", rd); end
            end
        end
        wait_until(f + 101);
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL sf_idle: got %h need 00000004", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic [7:0]  b [3];
        logic [9:0]  fr;
        logic [31:0] exp_st;
        int f, base;
        b = '{8'h41, 8'h42, 8'h43};
        wb_write(A_DATA, 32'h41, 4'h1);
        f = last_ack + 1;
        wb_write(A_DATA, 32'h42, 4'h1);
        wb_write(A_DATA, 32'h43, 4'h1);
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h201) begin errors++; $display("FAIL b2b_level2: got %h need 00000201", rd); end
        for (int j = 0; j < 3; j++) begin
            base = f + 101 * j;
            fr = {1'b1, b[j], 1'b0};
            if (j > 0) begin
                wait_until(base - 1);
                checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL b2b_gap%0d: got %b need 1", j, uart_tx); end
                wait_until(base);
                checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL b2b_pitch%0d: got %b need 0", j, uart_tx); end
                exp_st = (j == 1) ? 32'h101 : 32'h5;
                wb_read(A_STAT, rd);
                checks++; if (rd !== exp_st) begin errors++; $display("FAIL b2b_level%0d: got %h need %h", j, rd, exp_st); end
            end
            for (int k = 0; k < 10; k++) begin
                wait_until(base + 10 * k + 5);
                checks++;
                if (uart_tx !== fr[k]) begin errors++; $display("FAIL b2b_f%0d_bit%0d: got %b need %b", j, k, uart_tx, fr[k]); end
            end
        end
        wait_until(f + 305);
    endtask

    task automatic test_overflow;
        logic [31:0] rd;
        logic [9:0]  fr;
        int f;
        fr = {1'b1, 8'h14, 1'b0};
        wb_write(A_DATA, 32'h10, 4'h1);
        f = last_ack + 1;
        for (int i = 1; i < 6; i++) wb_write(A_DATA, 32'h10 + i, 4'h1);
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h40B) begin errors++; $display("FAIL ovf_full: got %h need 0000040b", rd); end
        wb_write(A_STAT, 32'h8, 4'h1);
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h403) begin errors++; $display("FAIL ovf_clear: got %h need 00000403", rd); end
        for (int k = 0; k < 10; k++) begin
            wait_until(f + 404 + 10 * k + 5);
            checks++;
            if (uart_tx !== fr[k]) begin errors++; $display("FAIL ovf_last_bit%0d: got %b need %b", k, uart_tx, fr[k]); end
        end
        wait_until(f + 510);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL ovf_dropped_sent: got %b need 1", uart_tx); end
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL ovf_drained: got %h need 00000004", rd); end
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        int f;
        wb_write(A_CTRL, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_CTRL, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL irq_ctrl_rd: got %h need 00000001", rd); end
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_on: got %b need 1", irq_o); end
        wb_write(A_DATA, 32'hA5, 4'h1);
        f = last_ack + 1;
        wait_until(f + 1);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b need 0", irq_o); end
        wait_until(f + 100);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_stop_end: got %b need 0", irq_o); end
        wait_until(f + 101);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b need 1", irq_o); end
        wb_write(A_CTRL, 32'h0, 4'h1);
        wait_until(last_ack + 1);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b need 0", irq_o); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] rd;
        int f;
        wb_write(A_DATA, 32'h00, 4'h1);
        f = last_ack + 1;
        wb_write(A_DATA, 32'h33, 4'h1);
        wait_until(f + 44);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rmf_bit3: got %b need 0", uart_tx); end
        reset = 1'b1;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rmf_async_tx: got %b need 1", uart_tx); end
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL rmf_status: got %h need 00000004", rd); end
        wait_until(last_ack + 3);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rmf_tx_idle: got %b need 1", uart_tx); end
    endtask

    task automatic test_simul_push_pop;
        logic [31:0] rd;
        logic [9:0]  fr;
        int f;
        fr = {1'b1, 8'h66, 1'b0};
        wb_write(A_DATA, 32'h61, 4'h1);
        f = last_ack + 1;
        wb_write(A_DATA, 32'h62, 4'h1);
        wb_write(A_DATA, 32'h63, 4'h1);
        wait_until(f + 100);
        wb_write(A_DATA, 32'h64, 4'h1);
        checks++; if (last_ack !== f + 101) begin errors++; $display("FAIL spp_ack_edge: got %0d need %0d", last_ack, f + 101); end
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL spp_pop_edge: got %b need 0", uart_tx); end
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h201) begin errors++; $display("FAIL spp_level2: got %h need 00000201", rd); end
        wb_write(A_DATA, 32'h65, 4'h1);
        wb_write(A_DATA, 32'h66, 4'h1);
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h403) begin errors++; $display("FAIL spp_full: got %h need 00000403", rd); end
        wait_until(f + 201);
        wb_write(A_DATA, 32'h67, 4'h1);
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h309) begin errors++; $display("FAIL spp_full_drop: got %h need 00000309", rd); end
        wb_write(A_STAT, 32'h8, 4'h1);
        for (int k = 0; k < 10; k++) begin
            wait_until(f + 505 + 10 * k + 5);
            checks++;
            if (uart_tx !== fr[k]) begin errors++; $display("FAIL spp_last_bit%0d: got %b need %b", k, uart_tx, fr[k]); end
        end
        wait_until(f + 611);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL spp_no_extra: got %b need 1", uart_tx); end
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL spp_drained: got %h need 00000004", rd); end
    endtask

    task automatic test_bus;
        logic [31:0] rd;
        logic        exp_ack;
        wb_read(A_STAT, rd);
        wb_read(A_DATA, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bus_rd_data: got %h need 0", rd); end
        wb_read(A_STAT, rd);
        wb_read(A_RSVD, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bus_rd_rsvd: got %h need 0", rd); end
        wb_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        wb_write(A_DATA, 32'h99, 4'h0);
        wait_until(last_ack + 3);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL bus_sel0_tx: got %b need 1", uart_tx); end
        wb_read(A_STAT, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL bus_sel0_status: got %h need 00000004", rd); end
        wb_read(A_CTRL, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bus_rsvd_wr: got %h need 0", rd); end
        wait_until(last_ack + 2);
        wb_adr_i = A_STAT; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock);
            #1;
            exp_ack = (i % 2 == 1);
            checks++;
            if (wb_ack_o !== exp_ack) begin errors++; $display("FAIL bus_ack_pattern%0d: got %b need %b", i, wb_ack_o, exp_ack); end
        end
        wb_stb_i = 1'b0;
        @(posedge clock);
        #1;
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL bus_no_stb: got %b need 0", wb_ack_o); end
        wb_cyc_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_irq();
        test_reset_midframe();
        test_simul_push_pop();
        test_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
